// File: rtl/conv_txn_scheduler_if.sv
// Bundle between the test-control requesters, the scheduler and the
// Convolution Tester M00_AXI engine.
//
// Handshake: req[i] acts as a level "valid" that is held until the
// scheduler answers with a one-cycle done[i] pulse (the "ready/ack"); err[i]
// qualifies only that pulse. Toward the engine, a rising INIT_AXI_TXN starts
// one transaction, and the engine answers with the TXN_DONE level. ERROR is
// only meaningful while TXN_DONE is high.
interface conv_txn_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        err;
  logic                      busy;
  logic [2:0]                gnt_id;
  logic                      M00_AXI_INIT_AXI_TXN;
  logic [ADDR_W-1:0]         M00_AXI_TXN_ADDR;
  logic                      M00_AXI_TXN_DONE;
  logic                      M00_AXI_ERROR;
  logic                      timeout_err;
  logic [1:0]                dbg_state;

  modport master (
    input  req, req_addr, M00_AXI_TXN_DONE, M00_AXI_ERROR,
    output done, err, busy, gnt_id, M00_AXI_INIT_AXI_TXN, M00_AXI_TXN_ADDR,
           timeout_err, dbg_state
  );

  modport slave (
    output req, req_addr, M00_AXI_TXN_DONE, M00_AXI_ERROR,
    input  done, err, busy, gnt_id, M00_AXI_INIT_AXI_TXN, M00_AXI_TXN_ADDR,
           timeout_err, dbg_state
  );
endinterface

// File: rtl/conv_txn_scheduler.sv
// Round-robin scheduler sharing one Convolution Tester AXI master engine
// among NUM_REQ requesters. One transaction runs at a time:
// IDLE (arbitrate) -> LAUNCH (INIT pulse) -> WAIT (engine busy) -> GAP.
// Optional watchdog in WAIT: define CONV_SCHED_TIMEOUT_EN.
module conv_txn_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 32,
  parameter int INIT_PULSE_LEN = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  conv_txn_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

  state_t            state;
  state_t            state_next;
  logic [15:0]       cnt;          // per-state cycle counter, cleared on entry
  logic [2:0]        rr_ptr;       // first requester to consider next time
  logic [2:0]        pick_id;
  logic              pick_vld;
  logic [ADDR_W-1:0] pick_addr;
  logic [7:0]        req_ext;
  logic [3:0]        idx;
  logic [2:0]        next_ptr;
  logic              wait_hit;
  logic              wait_timeout;

  assign req_ext  = 8'(bus.req);
  assign wait_hit = (state == WAIT) && bus.M00_AXI_TXN_DONE;
  assign next_ptr = (bus.gnt_id == 3'(NUM_REQ - 1)) ? 3'd0 : bus.gnt_id + 3'd1;

  // Round-robin search from rr_ptr with wrap; scanned downward so the
  // requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    pick_vld  = 1'b0;
    pick_id   = 3'd0;
    pick_addr = '0;
    idx       = 4'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
      if (req_ext[idx[2:0]]) begin
        pick_vld = 1'b1;
        pick_id  = idx[2:0];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_id == 3'(i)) pick_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and state-decoded outputs; INIT is high only in LAUNCH.
  always_comb begin
    state_next               = state;
    bus.M00_AXI_INIT_AXI_TXN = 1'b0;
    bus.busy                 = (state != IDLE);
    bus.dbg_state            = state;
    case (state)
      IDLE: begin
        if (pick_vld) state_next = LAUNCH;
      end
      LAUNCH: begin
        bus.M00_AXI_INIT_AXI_TXN = 1'b1;
        if (cnt == 16'(INIT_PULSE_LEN - 1)) state_next = WAIT;
      end
      WAIT: begin
        if (wait_hit || wait_timeout) state_next = GAP;
      end
      GAP: begin
        if (GAP_CYCLES == 0 || cnt == 16'(GAP_CYCLES - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant capture, completion pulses and round-robin pointer update.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cnt                  <= '0;
      rr_ptr               <= 3'd0;
      bus.gnt_id           <= 3'd0;
      bus.M00_AXI_TXN_ADDR <= '0;
      bus.done             <= '0;
      bus.err              <= '0;
    end else begin
      cnt      <= (state_next != state) ? 16'd0 : cnt + 16'd1;
      bus.done <= '0;
      bus.err  <= '0;
      if (state == IDLE && pick_vld) begin
        bus.gnt_id           <= pick_id;
        bus.M00_AXI_TXN_ADDR <= pick_addr;
      end
      if (wait_hit || wait_timeout) begin
        bus.done <= NUM_REQ'(1'b1) << bus.gnt_id;
        bus.err  <= NUM_REQ'(wait_hit ? bus.M00_AXI_ERROR : 1'b1) << bus.gnt_id;
        rr_ptr   <= next_ptr;
      end
    end
  end

`ifdef CONV_SCHED_TIMEOUT_EN
  // Watchdog: TXN_DONE takes priority over an expiry in the same cycle.
  assign wait_timeout = (state == WAIT) && !bus.M00_AXI_TXN_DONE &&
                        (cnt == 16'(TIMEOUT_CYCLES - 1));

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)            bus.timeout_err <= 1'b0;
    else if (wait_timeout) bus.timeout_err <= 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wait_timeout       = 1'b0;
  assign bus.timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_conv_txn_scheduler.sv
// Bench for conv_txn_scheduler: directed scenarios followed by randomized
// request mixes, checked against a round-robin reference model and an
// expected-completion queue.
module tb_conv_txn_scheduler;
  localparam int NUM_REQ        = 4;
  localparam int ADDR_W         = 32;
  localparam int INIT_PULSE_LEN = 2;
  localparam int GAP_CYCLES     = 4;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int SBW            = 2 * NUM_REQ;

  logic tb_ACLK   = 1'b0;
  logic tb_ARESET = 1'b1;

  conv_txn_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) bus ();

  conv_txn_scheduler #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .INIT_PULSE_LEN(INIT_PULSE_LEN),
    .GAP_CYCLES(GAP_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .ACLK(tb_ACLK),
    .ARESET(tb_ARESET),
    .bus(bus.master)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  always #5 tb_ACLK = ~tb_ACLK;

  int cyc = 0;
  initial forever begin
    @(posedge tb_ACLK);
    cyc++;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int m_rr   = 0;            // model round-robin pointer
  int last_done_cyc = -1;
  logic [SBW-1:0] exp_q[$];  // expected {err, done} per completion
  logic [SBW-1:0] sb_got;
  logic [ADDR_W-1:0] addr_a[NUM_REQ];

  // engine model configuration
  int   eng_lat   = 10;
  int   eng_hold  = 1;
  logic eng_err   = 1'b0;
  bit   eng_never = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] m, input int p);
    for (int k = 0; k < NUM_REQ; k++)
      if (m[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic pack_addrs();
    for (int i = 0; i < NUM_REQ; i++) bus.req_addr[i*ADDR_W +: ADDR_W] = addr_a[i];
  endtask

  task automatic do_reset();
    tb_ARESET = 1'b1;
    repeat (2) @(negedge tb_ACLK);
    tb_ARESET = 1'b0;
    m_rr = 0;
    last_done_cyc = -1;
  endtask

  // ---------------- engine model ----------------
  // Raises TXN_DONE eng_lat cycles after each INIT rising edge, holds it
  // eng_hold cycles; ERROR is the inverse of the answer outside DONE.
  initial begin
    int   cnt_e  = 0;
    int   hold_e = 0;
    logic init_q = 1'b0;
    logic cur_err = 1'b0;
    bus.M00_AXI_TXN_DONE = 1'b0;
    bus.M00_AXI_ERROR    = 1'b0;
    forever begin
      @(posedge tb_ACLK);
      #2;
      if (tb_ARESET) begin
        cnt_e = 0; hold_e = 0; init_q = 1'b0;
        bus.M00_AXI_TXN_DONE = 1'b0;
        bus.M00_AXI_ERROR    = 1'b0;
      end else begin
        if (hold_e > 0) begin
          hold_e--;
          if (hold_e == 0) begin
            bus.M00_AXI_TXN_DONE = 1'b0;
            bus.M00_AXI_ERROR    = ~cur_err;
          end
        end else if (cnt_e > 0) begin
          cnt_e--;
          if (cnt_e == 0) begin
            bus.M00_AXI_TXN_DONE = 1'b1;
            bus.M00_AXI_ERROR    = cur_err;
            hold_e = eng_hold;
          end
        end
        if (bus.M00_AXI_INIT_AXI_TXN && !init_q && !eng_never) begin
          cnt_e   = eng_lat;
          cur_err = eng_err;
        end
        init_q = bus.M00_AXI_INIT_AXI_TXN;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial forever begin
    @(negedge tb_ACLK);
    if (tb_ARESET === 1'b0) begin
      check("err_outside_done", 64'(bus.err & ~bus.done), 0);
      check("init_without_busy", 64'(bus.M00_AXI_INIT_AXI_TXN & ~bus.busy), 0);
      if (bus.done !== '0) begin
        if (exp_q.size() == 0) check("unexpected_done", 64'(bus.done), 0);
        else begin
          sb_got = exp_q.pop_front();
          check("done_err_vec", 64'({bus.err, bus.done}), 64'(sb_got));
        end
      end
    end
  end

  // ---------------- driver task: one full transaction ----------------
  task automatic run_txn(input string tag, input int exp_id, input logic exp_err,
                         input logic [ADDR_W-1:0] exp_addr, input bit is_timeout);
    int budget;
    int n_init;
    int n_wait;
    int n_bad;
    int dn_cyc;
    exp_q.push_back({NUM_REQ'(exp_err) << exp_id, NUM_REQ'(1) << exp_id});
    budget = 400;
    while (bus.M00_AXI_INIT_AXI_TXN !== 1'b1 && budget > 0) begin
      @(negedge tb_ACLK);
      budget--;
    end
    check({tag, "_launch_seen"}, budget > 0, 1);
    if (budget == 0) return;
    check({tag, "_gnt_id"}, bus.gnt_id, exp_id);
    check({tag, "_txn_addr"}, bus.M00_AXI_TXN_ADDR, exp_addr);
    if (last_done_cyc >= 0) check({tag, "_gap_ok"}, (cyc - last_done_cyc) > GAP_CYCLES, 1);
    n_init = 0;
    while (bus.M00_AXI_INIT_AXI_TXN === 1'b1 && n_init < 40) begin
      n_init++;
      @(negedge tb_ACLK);
    end
    check({tag, "_init_len"}, n_init, INIT_PULSE_LEN);
    n_wait = 0; n_bad = 0; dn_cyc = -1;
    while (bus.done === '0 && n_wait < 400) begin
      if (bus.M00_AXI_TXN_DONE === 1'b1 && dn_cyc < 0) dn_cyc = cyc;
      if (bus.M00_AXI_INIT_AXI_TXN !== 1'b0) n_bad++;
      n_wait++;
      @(negedge tb_ACLK);
    end
    check({tag, "_done_seen"}, n_wait < 400, 1);
    if (n_wait >= 400) return;
    check({tag, "_init_low_in_wait"}, n_bad, 0);
    if (is_timeout) check({tag, "_wait_len"}, n_wait, TIMEOUT_CYCLES);
    else            check({tag, "_done_latency"}, cyc - dn_cyc, 1);
    check({tag, "_addr_hold"}, bus.M00_AXI_TXN_ADDR, exp_addr);
    last_done_cyc = cyc;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int order2[5] = '{0, 1, 2, 3, 0};
    int n;
    int exp_id;
    logic [NUM_REQ-1:0] pending;

    bus.req = '0;
    for (int i = 0; i < NUM_REQ; i++) addr_a[i] = 32'h1000_0000 * (i + 1);
    pack_addrs();
    do_reset();

    // reset values
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_gnt_id", bus.gnt_id, 0);
    check("rst_init", bus.M00_AXI_INIT_AXI_TXN, 0);
    check("rst_txn_addr", bus.M00_AXI_TXN_ADDR, 0);
    check("rst_timeout_err", bus.timeout_err, 0);

    // single request, 2-cycle INIT, 4 GAP cycles
    addr_a[0] = 32'h4000_0000; pack_addrs();
    eng_lat = 20; eng_err = 1'b0; eng_hold = 1;
    bus.req = 4'b0001;
    @(negedge tb_ACLK);
    check("t1_grant_next_cycle", bus.M00_AXI_INIT_AXI_TXN, 1);
    run_txn("t1", 0, 1'b0, 32'h4000_0000, 1'b0);
    bus.req = '0;
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin
      n++;
      @(negedge tb_ACLK);
    end
    check("t1_gap_busy_cycles", n, GAP_CYCLES);

    // all requesting: rotation 0,1,2,3,0
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      eng_lat = $urandom_range(3, 15);
      run_txn("t2", order2[i], 1'b0, addr_a[order2[i]], 1'b0);
      if (i == 4) bus.req = '0;
    end
    m_rr = 1;

    // engine error reported to requester 2 only
    eng_err = 1'b1; eng_lat = 8;
    bus.req = 4'b0100;
    run_txn("t3", 2, 1'b1, addr_a[2], 1'b0);
    bus.req = '0;
    m_rr = 3;
    eng_err = 1'b0;

    // reset during WAIT of requester 1, then re-served
    tb_ARESET = 1'b1;
    repeat (2) @(negedge tb_ACLK);
    tb_ARESET = 1'b0;
    m_rr = 0; last_done_cyc = -1;
    eng_lat = 30;
    bus.req = 4'b0010;
    n = 0;
    while (bus.M00_AXI_INIT_AXI_TXN !== 1'b1 && n < 50) begin n++; @(negedge tb_ACLK); end
    while (bus.M00_AXI_INIT_AXI_TXN === 1'b1 && n < 50) begin n++; @(negedge tb_ACLK); end
    check("t4_reached_wait", n < 50, 1);
    repeat (5) @(negedge tb_ACLK);
    tb_ARESET = 1'b1;
    #1;
    check("t4_async_init", bus.M00_AXI_INIT_AXI_TXN, 0);
    check("t4_async_busy", bus.busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge tb_ACLK);
      check("t4_no_done_in_reset", bus.done, 0);
    end
    tb_ARESET = 1'b0;
    eng_lat = 10;
    run_txn("t4_regrant", 1, 1'b0, addr_a[1], 1'b0);
    m_rr = 2;

    // pointer at 2 with requesters 0,1 pending: wrap to 0 then 1
    bus.req = 4'b0011;
    run_txn("t5_first", 0, 1'b0, addr_a[0], 1'b0);
    bus.req = 4'b0010;
    run_txn("t5_second", 1, 1'b0, addr_a[1], 1'b0);
    bus.req = '0;
    m_rr = 2;

`ifdef CONV_SCHED_TIMEOUT_EN
    // engine never answers: watchdog completes with error
    eng_never = 1'b1;
    bus.req = 4'b1000;
    run_txn("t6_timeout", 3, 1'b1, addr_a[3], 1'b1);
    bus.req = '0;
    eng_never = 1'b0;
    check("t6_timeout_err_set", bus.timeout_err, 1);
    eng_lat = 6;
    bus.req = 4'b0001;
    run_txn("t6_next", 0, 1'b0, addr_a[0], 1'b0);
    bus.req = '0;
    check("t6_timeout_err_sticky", bus.timeout_err, 1);
    m_rr = 1;
`else
    check("t6_timeout_err_off", bus.timeout_err, 0);
`endif

    // randomized request mixes against the round-robin model
    pending = '0;
    for (int it = 0; it < 24; it++) begin
      pending = pending | NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      if (pending == '0) pending = NUM_REQ'(1) << $urandom_range(0, NUM_REQ - 1);
      for (int i = 0; i < NUM_REQ; i++) addr_a[i] = $urandom;
      pack_addrs();
      eng_err  = 1'($urandom_range(0, 1));
      eng_lat  = $urandom_range(1, 25);
      eng_hold = $urandom_range(1, 3);
      bus.req  = pending;
      exp_id   = rr_pick(pending, m_rr);
      run_txn("rnd", exp_id, eng_err, addr_a[exp_id], 1'b0);
      pending[exp_id] = 1'b0;
      bus.req = pending;
      m_rr = (exp_id + 1) % NUM_REQ;
    end
    bus.req = '0;
    repeat (15) @(negedge tb_ACLK);
    check("end_idle", bus.busy, 0);
    check("end_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, observed time %0t", $time);
    $fatal(1, "global time bound reached");
  end

endmodule

// File: doc/conv_txn_scheduler.md
Name: conv_txn_scheduler

Overview:
- Round-robin scheduler that shares the single Convolution Tester AXI master engine among NUM_REQ requesters.
- Accepts a per-requester transaction request with a target base address.
- Drives the engine's INIT_AXI_TXN start strobe, waits for TXN_DONE and returns a per-requester done/error result.
- Sits between the test-control logic and the M00_AXI engine in the block design.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, width of per-requester base address
INIT_PULSE_LEN, 2, cycles INIT_AXI_TXN is held high per launch (1..15)
GAP_CYCLES, 4, idle cycles after TXN_DONE before next launch (0..15)
TIMEOUT_CYCLES, 4096, watchdog limit in WAIT (used only with optional feature)

Ports:
ACLK  in  1  system clock, all logic on rising edge
ARESET  in  1  asynchronous, active-high reset
req  in  NUM_REQ  level request per requester; held until matching done
req_addr  in  NUM_REQ*ADDR_W  base address per requester, slice i = requester i
done  out  NUM_REQ  one-cycle completion pulse per requester
err  out  NUM_REQ  error result, valid in the cycle done[i] is high, else 0
busy  out  1  high whenever state != IDLE
gnt_id  out  3  index of current/last granted requester
M00_AXI_INIT_AXI_TXN  out  1  start strobe to engine
M00_AXI_TXN_ADDR  out  ADDR_W  registered base address for current transaction
M00_AXI_TXN_DONE  in  1  engine completion, sampled level
M00_AXI_ERROR  in  1  engine error flag, sampled with TXN_DONE
timeout_err  out  1  sticky watchdog flag (0 when feature compiled out)

Behaviour:
- Reset (async assert, sync release):
  - outputs: done=0, err=0, busy=0, gnt_id=0, M00_AXI_INIT_AXI_TXN=0, M00_AXI_TXN_ADDR=0, timeout_err=0
  - internals: rr pointer = 0, state IDLE
- Reset mid-transaction aborts immediately. There is no completion pulse for the aborted requester; it must keep req high to be re-served.
- FSM states: IDLE, LAUNCH, WAIT, GAP.
- IDLE:
  - If any req bit is set, pick the first set bit searching from rr pointer upward with wrap.
  - Register gnt_id and M00_AXI_TXN_ADDR from that requester's slice.
  - Go to LAUNCH next cycle. Arbitration is 1 cycle, so the grant is visible the cycle after req is seen.
- LAUNCH:
  - INIT_AXI_TXN=1 for exactly INIT_PULSE_LEN cycles, then drop to 0.
  - Go to WAIT.
  - INIT is never high in any other state, so the engine sees a clean rising edge per launch.
- WAIT:
  - On the first cycle M00_AXI_TXN_DONE=1, the next cycle pulses done[gnt_id]=1 for one cycle with err[gnt_id]=M00_AXI_ERROR sampled on the DONE cycle.
  - rr pointer = gnt_id+1 (wrap to 0 after NUM_REQ-1).
  - Go to GAP.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE. GAP_CYCLES=0 means go to IDLE next cycle.
  - TXN_DONE still high in GAP/IDLE is ignored; only WAIT samples it.
- req behaviour:
  - A requester dropping req after grant does not cancel the transaction; it still gets done.
  - req changes during LAUNCH/WAIT/GAP have no effect until IDLE.
  - Simultaneous requests are resolved by round-robin only; no starvation, worst-case wait is NUM_REQ-1 transactions.
- M00_AXI_TXN_ADDR holds its value from grant until the next grant.
- gnt_id width is fixed at 3; upper bits are 0 for small NUM_REQ.

Optional Feature:
- Macro CONV_SCHED_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without TXN_DONE: pulse done[gnt_id] with err[gnt_id]=1, set timeout_err sticky (cleared only by ARESET), advance rr pointer, go to GAP.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - timeout_err tied to 0.

Test Plan:
1. Reset release, req=4'b0001, addr0=0x4000_0000; engine model raises TXN_DONE 20 cycles after INIT rising edge with ERROR=0 -> INIT high exactly 2 cycles, TXN_ADDR=0x4000_0000, done[0] one cycle after DONE with err[0]=0, then busy low after 4 GAP cycles.
2. req=4'b1111 held continuously, engine always completes -> grant order 0,1,2,3,0 with exactly one INIT rising edge per transaction and ≥4 idle cycles between consecutive launches.
3. req=4'b0100; engine returns DONE with ERROR=1 -> done[2]=1 with err[2]=1 in the same cycle; all other err bits remain 0.
4. ARESET asserted 5 cycles into WAIT of requester 1 -> INIT and busy go 0 asynchronously, no done pulse. After release with req[1] still high, requester 1 is re-granted and completes normally.
5. rr pointer at 2, req=4'b0011 -> requester 0 is granted first (wrap), then requester 1.
6. With CONV_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=64, engine never asserts DONE -> done[gnt_id]=1 with err=1 after 64 WAIT cycles, timeout_err=1 and stays 1. The next request is then served normally.
